// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-library types and sizing helpers
package arith_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit count needed for a counter that runs 0 .. width-1.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - gate-level full subtractor from two half subtractors and an OR
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    logic w_d1;
    logic w_bo1;
    logic w_bo2;

    half_subtractor u_hs0 (
        .i_a      (A),
        .i_b      (B),
        .o_diff   (w_d1),
        .o_borrow (w_bo1)
    );

    half_subtractor u_hs1 (
        .i_a      (w_d1),
        .i_b      (Bin),
        .o_diff   (Diff),
        .o_borrow (w_bo2)
    );

    or u_or (Bout, w_bo1, w_bo2);

endmodule

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - gate-level half subtractor (a - b)
module half_subtractor (
    input  logic i_a,
    input  logic i_b,
    output logic o_diff,
    output logic o_borrow
);

    logic w_a_n;

    xor u_xor (o_diff, i_a, i_b);
    not u_not (w_a_n, i_a);
    and u_and (o_borrow, w_a_n, i_b);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin, LSB first, one bit per clock
// Optional overflow output Ovf enabled by SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_next;
    logic [CW-1:0]    r_cnt;
    logic             r_brw;
    logic             w_d;
    logic             w_bo;
    logic             w_accept;
    logic             w_last;

    full_subtractor u_fs (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Bin  (r_brw),
        .Diff (w_d),
        .Bout (w_bo)
    );

    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last    = (r_state == RUN) && (r_cnt == LAST);
    // New difference bit enters at the MSB so the LSB-first stream lands in place.
    assign w_sh_next = (r_sh >> 1) | {w_d, {(WIDTH-1){1'b0}}};

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sh  <= '0;
            r_cnt <= '0;
            r_brw <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            Ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_brw <= Bin;
            r_cnt <= '0;
            r_sh  <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_brw <= w_bo;
            r_cnt <= r_cnt + 1'b1;
            r_sh  <= w_sh_next;
            if (w_last) begin
                Diff <= w_sh_next;
                Bout <= w_bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                // Borrow into the MSB is the flop value while the MSB is processed.
                Ovf  <= r_brw ^ w_bo;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         Bin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         Ovf;
`endif

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           n_checks  = 0;
    int           n_pass    = 0;
    logic [W-1:0] prev_diff = '0;
    logic         prev_bout = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t model(input int a, input int b, input int bin);
        exp_t e;
        int   full;
        int   sa;
        int   sb;
        int   r;
        full   = a - b - bin;
        e.diff = W'(full);
        e.bout = (a < b + bin);
        sa     = (a >= 2**(W-1)) ? a - 2**W : a;
        sb     = (b >= 2**(W-1)) ? b - 2**W : b;
        r      = sa - sb - bin;
        e.ovf  = (r < -(2**(W-1))) || (r > 2**(W-1) - 1);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_diff = Diff;
            prev_bout = Bout;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("diff", {24'd0, Diff}, {24'd0, mon_e.diff});
                check("bout", {31'd0, Bout}, {31'd0, mon_e.bout});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                check("ovf", {31'd0, Ovf}, {31'd0, mon_e.ovf});
`endif
            end
            prev_diff = Diff;
            prev_bout = Bout;
        end else begin
            check("diff_hold", {24'd0, Diff}, {24'd0, prev_diff});
            check("bout_hold", {31'd0, Bout}, {31'd0, prev_bout});
        end
    end

    // Called at posedge+1; the following edge is the start edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input bit push);
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        if (push) exp_q.push_back(model(int'(a), int'(b), int'(bin)));
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        Bin   = 1'($urandom);
    endtask

    task automatic wait_done(input int n0);
        int n;
        n = n0;
        while (!done && n < W + 4) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, W);
        check("done_seen", {31'd0, done}, 32'd1);
        check("busy_done", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [4];
        corners[0] = '0;
        corners[1] = '1;
        corners[2] = W'(2**(W-1));
        corners[3] = W'(2**(W-1) - 1);
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, Diff}, 32'd0);
        check("rst_bout", {31'd0, Bout}, 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("rst_ovf", {31'd0, Ovf}, 32'd0);
`endif
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        issue(8'd200, 8'd55, 1'b0, 1'b1);
        wait_done(0);
        check("diff_200_55", {24'd0, Diff}, 32'd145);
        @(posedge clk);
        #1;
        check("idle_done_low", {31'd0, done}, 32'd0);
        check("idle_busy_low", {31'd0, busy}, 32'd0);

        issue(8'd5, 8'd10, 1'b0, 1'b1);
        wait_done(0);
        check("diff_5_10", {24'd0, Diff}, 32'd251);
        check("bout_5_10", {31'd0, Bout}, 32'd1);
        @(posedge clk);
        #1;
        issue(8'd0, 8'd0, 1'b1, 1'b1);
        wait_done(0);
        check("diff_0_0_1", {24'd0, Diff}, 32'd255);
        check("bout_0_0_1", {31'd0, Bout}, 32'd1);
        @(posedge clk);
        #1;

        // Start while busy must be ignored.
        issue(8'd9, 8'd3, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        A = 8'd1;
        B = 8'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3);
        check("diff_9_3", {24'd0, Diff}, 32'd6);
        repeat (W + 2) @(posedge clk);
        #1;

        // Reset mid-operation discards the result.
        issue(8'd100, 8'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_diff", {24'd0, Diff}, 32'd0);
        check("midrst_bout", {31'd0, Bout}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1;
        issue(8'd7, 8'd7, 1'b0, 1'b1);
        wait_done(0);
        check("diff_7_7", {24'd0, Diff}, 32'd0);

        // Back-to-back: second start lands in the done cycle.
        @(posedge clk);
        #1;
        issue(8'd20, 8'd4, 1'b0, 1'b1);
        wait_done(0);
        check("diff_20_4", {24'd0, Diff}, 32'd16);
        issue(8'd3, 8'd2, 1'b0, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("diff_held_16", {24'd0, Diff}, 32'd16);
        wait_done(4);
        check("diff_3_2", {24'd0, Diff}, 32'd1);

        @(posedge clk);
        #1;
        issue(8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(0);
        check("diff_80_01", {24'd0, Diff}, 32'h7F);
        check("bout_80_01", {31'd0, Bout}, 32'd0);
        issue(8'h05, 8'h03, 1'b0, 1'b1);
        wait_done(0);
        check("diff_05_03", {24'd0, Diff}, 32'h02);

        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            issue(pick(), pick(), 1'($urandom), 1'b1);
            wait_done(0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
